uart8_transmitter: RTL and testbench
====================================

UART8_TRANSMITTER -- requirements
Module: uart8_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (16x oversample clock, matching the receiver).
REQ-002 SHALL have port clk  input  1  clock, 16x baud rate; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1  enable; low forces idle.
REQ-005 SHALL have port start  input  1  transmit request, sampled in IDLE.
REQ-006 SHALL have port in  input  8  byte to transmit.
REQ-007 SHALL have port out  output  1  serial tx line, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse at end of frame.

Function
REQ-010 SHALL implement states IDLE, START_BIT, DATA_BITS, PARITY_BIT (only with UART8_TX_PARITY_EN), STOP_BIT.
REQ-011 SHALL accept a request when state=IDLE, en=1 and start=1 at a rising edge: latch in, set busy=1, set out=0, enter START_BIT.
REQ-012 SHALL ignore start while busy=1, and SHALL not alter the latched byte if in changes mid-frame.
REQ-013 SHALL hold every bit for exactly CLKS_PER_BIT cycles using a counter that resets to 0 at each bit boundary.
REQ-014 SHALL send the start bit (0), then data bits LSB first (bit 0..7), then the stop bit (1); frame = 10*CLKS_PER_BIT cycles (160 at default).
REQ-015 SHALL use a 3-bit bit index in DATA_BITS, leaving DATA_BITS after index 7 without wrap-around side effects.
REQ-016 SHALL, at the edge ending the last stop-bit cycle, enter IDLE, drive busy=0 and done=1 for exactly one cycle; out stays 1.
REQ-017 SHALL accept start in the same cycle done=1 (back-to-back frames: one idle-high cycle between stop bit and next start bit).
REQ-018 SHALL drive out only from a register (glitch-free, no combinational path from in or start).
REQ-019 SHALL, if en falls mid-frame, abort at the next edge: state IDLE, out=1, busy=0, done=0, counters cleared; no done pulse for the aborted frame.
REQ-020 SHALL, if en=0 and start=1 in IDLE, not start a frame.
REQ-021 SHALL recover to IDLE from any unreachable state encoding on the next edge with out=1.

Reset
REQ-022 SHALL, while rst=1, immediately force state=IDLE, out=1, busy=0, done=0, bit index=0, counter=0, latched data=0, independent of clk.
REQ-023 SHALL, on rst mid-frame, discard the frame; first accepted start after release begins a fresh frame.

Configuration
REQ-024 SHALL, with macro UART8_TX_PARITY_EN defined, insert PARITY_BIT between DATA_BITS and STOP_BIT, sending even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT cycles.
REQ-025 SHALL, without UART8_TX_PARITY_EN, omit PARITY_BIT and all parity logic; frame = 10*CLKS_PER_BIT cycles.

Verification
REQ-026 SHALL cover: reset release, en=1, start pulse with in=8'h55 -> out low 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, stop high 16 cycles; busy high 160 cycles; done one pulse.
REQ-027 SHALL cover: start held high continuously with in=8'hA3 -> consecutive frames 161 cycles apart, done pulse each frame, no missed or extra start bit.
REQ-028 SHALL cover: start pulse during busy with in changed to 8'hFF -> ignored; frame completes with original byte.
REQ-029 SHALL cover: en dropped at cycle 70 of a frame -> out=1, busy=0 next edge, no done; next start gives a complete correct frame.
REQ-030 SHALL cover: rst asserted between clock edges mid-frame -> out=1, busy=0 without waiting for clk.
REQ-031 SHALL cover, with UART8_TX_PARITY_EN: in=8'h07 -> parity bit 1 for 16 cycles before stop; busy high 176 cycles.

Source files
------------

// File: rtl/uart8_transmitter.sv
// 8N1 UART transmitter, one bit every CLKS_PER_BIT clocks, LSB first.
// Define UART8_TX_PARITY_EN to add an even-parity bit before the stop bit.
module uart8_transmitter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic [7:0] in,
  output logic       out,
  output logic       busy,
  output logic       done
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
`ifdef UART8_TX_PARITY_EN
    PARITY_BIT = 3'd4,
`endif
    STOP_BIT   = 3'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx_q;
  logic [2:0]    idx_d;
  logic [7:0]    data_q;
  logic          out_q;
  logic          busy_q;
  logic          done_q;
  logic          bit_end;

  // Bit-time bookkeeping shared by every non-idle state.
  always_comb begin
    bit_end = (cnt_q == CNT_MAX);
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q + 3'd1;
  end

  // Frame sequencer; every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (!en) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          idx_q  <= '0;
          out_q  <= 1'b1;
          busy_q <= 1'b0;
          if (start) begin
            data_q  <= in;
            out_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START_BIT;
          end
        end
        START_BIT: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= data_q[0];
            state_q <= DATA_BITS;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DATA_BITS: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
`ifdef UART8_TX_PARITY_EN
              out_q   <= ^data_q;
              state_q <= PARITY_BIT;
`else
              out_q   <= 1'b1;
              state_q <= STOP_BIT;
`endif
            end else begin
              idx_q <= idx_d;
              out_q <= data_q[idx_d];
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
`ifdef UART8_TX_PARITY_EN
        PARITY_BIT: begin
          if (bit_end) begin
            cnt_q   <= '0;
            out_q   <= 1'b1;
            state_q <= STOP_BIT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
`endif
        STOP_BIT: begin
          if (bit_end) begin
            cnt_q   <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
          out_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart8_transmitter.sv
// Bench for uart8_transmitter: queued expected bytes vs decoded frames.
// Honours UART8_TX_PARITY_EN for the frame layout.
module tb_uart8_transmitter;

  localparam int C = 16;
`ifdef UART8_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       start;
  logic [7:0] din;
  logic       out;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stray = 0;
  int frames_ok = 0;
  bit abort_armed = 1'b0;
  logic [7:0] q[$];
  int starts[$];

  uart8_transmitter #(.CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .start(start),
    .in   (din),
    .out  (out),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Frame monitor: decode out, compare with the queue head.
  initial begin : mon
    logic       s [0:FRAME-1];
    logic [7:0] exp_b;
    logic [7:0] got_b;
    int         nbad;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && out === 1'b0) begin
        chk("frame_expected", 32'(q.size() > 0), 1);
        exp_b = 8'h00;
        if (q.size() > 0) exp_b = q.pop_front();
        starts.push_back(cyc);
        s[0] = out;
        aborted = 1'b0;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (busy !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          s[k] = out;
          if (done) stray++;
        end
        if (aborted) begin
          chk("abort_armed", 32'(abort_armed), 1);
          chk("abort_out", 32'(out), 1);
          chk("abort_done", 32'(done), 0);
          abort_armed = 1'b0;
        end else begin
          @(negedge clk);
          chk("end_busy", 32'(busy), 0);
          chk("end_done", 32'(done), 1);
          chk("end_out", 32'(out), 1);
          nbad = 0;
          for (int b = 0; b < NB; b++)
            for (int j = 1; j < C; j++)
              if (s[b*C+j] !== s[b*C]) nbad++;
          chk("bit_stable", 32'(nbad), 0);
          chk("start_bit", 32'(s[0]), 0);
          for (int i = 0; i < 8; i++)
            got_b[i] = s[(1+i)*C];
          chk("data", 32'(got_b), 32'(exp_b));
`ifdef UART8_TX_PARITY_EN
          chk("parity", 32'(s[9*C]), 32'(^exp_b));
`endif
          chk("stop_bit", 32'(s[(NB-1)*C]), 1);
          frames_ok++;
        end
      end else if (done === 1'b1) begin
        stray++;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #2;
    din = b;
    start = 1'b1;
    q.push_back(b);
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 400), 1);
    repeat (3) @(posedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int s0;
    int d;
    int n;
    rst = 1'b1;
    en = 1'b0;
    start = 1'b0;
    din = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_out", 32'(out), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // en low blocks a request in idle
    start = 1'b1;
    din = 8'hE1;
    repeat (5) @(posedge clk);
    #2;
    chk("en0_busy", 32'(busy), 0);
    chk("en0_out", 32'(out), 1);
    start = 1'b0;
    en = 1'b1;
    repeat (2) @(posedge clk);

    // basic 0x55 frame
    send(8'h55);
    wait_idle();

    // start held high: back-to-back frames
    s0 = starts.size();
    @(posedge clk); #2;
    din = 8'hA3;
    start = 1'b1;
    repeat (3) q.push_back(8'hA3);
    d = 0;
    n = 0;
    while (d < 2 && n < 1000) begin
      @(negedge clk);
      if (done) d++;
      n++;
    end
    chk("held_done_cnt", 32'(d), 2);
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();
    chk("held_frames", 32'(starts.size() - s0), 3);
    if (starts.size() >= s0 + 3) begin
      chk("period1", 32'(starts[s0+1] - starts[s0]),
          32'(FRAME + 1));
      chk("period2", 32'(starts[s0+2] - starts[s0+1]),
          32'(FRAME + 1));
    end

    // start during busy with new data is ignored
    send(8'h3C);
    repeat (50) @(posedge clk);
    #2;
    din = 8'hFF;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();

    // en dropped at cycle 70 of a frame
    send(8'h96);
    repeat (68) @(posedge clk);
    #2;
    abort_armed = 1'b1;
    en = 1'b0;
    @(posedge clk); #2;
    chk("en_abort_busy", 32'(busy), 0);
    chk("en_abort_out", 32'(out), 1);
    repeat (20) @(posedge clk);
    #2;
    en = 1'b1;
    send(8'h5A);
    wait_idle();

    // async reset between edges mid-frame
    send(8'hC3);
    repeat (40) @(posedge clk);
    #3;
    abort_armed = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_out", 32'(out), 1);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    send(8'h81);
    wait_idle();

`ifdef UART8_TX_PARITY_EN
    send(8'h07);
    wait_idle();
`endif

    repeat (5) @(posedge clk);
    chk("q_empty", 32'(q.size()), 0);
    chk("stray_done", 32'(stray), 0);
    chk("abort_seen", 32'(abort_armed), 0);
`ifdef UART8_TX_PARITY_EN
    chk("frames_ok", 32'(frames_ok), 8);
`else
    chk("frames_ok", 32'(frames_ok), 7);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
